// File: rtl/bit_exponent_encoder.sv
// Serialises the index of every set bit of an operand, LSB first. First beat is valid the cycle after accept.
// Outputs hold under out_ready=0; a new operand is taken only in IDLE or on the last-beat transfer.
module bit_exponent_encoder #(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic                  out_last,
    output logic                  out_zero,
    output logic [EXP_WIDTH:0]    out_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] residual_q, residual_d;
    logic                  zero_q, zero_d;
    logic [EXP_WIDTH:0]    count_q, count_d;

    logic [EXP_WIDTH-1:0]  low_idx;
    logic                  single_bit;
    logic                  busy;
    logic                  beat_xfer;
    logic                  accept;

    // Scan from MSB down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (residual_q[i]) begin
                low_idx = EXP_WIDTH'(i);
            end
        end
    end

    assign single_bit = (residual_q != '0) &&
                        ((residual_q & (residual_q - DATA_WIDTH'(1))) == '0);

    assign busy      = (state_q == BUSY);
    assign out_valid = busy;
    assign out_exp   = low_idx;
    assign out_last  = busy & (zero_q | single_bit);
    assign out_zero  = busy & zero_q;
    assign out_count = count_q;

    assign beat_xfer = out_valid & out_ready;
    assign in_ready  = ~busy | (beat_xfer & out_last);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        zero_d     = zero_q;
        count_d    = count_q;
        if (accept) begin
            state_d    = BUSY;
            residual_d = in_data;
            zero_d     = (in_data == '0);
            count_d    = '0;
        end else if (beat_xfer) begin
            if (out_last) begin
                state_d    = IDLE;
                residual_d = '0;
                zero_d     = 1'b0;
                count_d    = '0;
            end else begin
                // Drop the lowest set bit just emitted.
                residual_d = residual_q & (residual_q - DATA_WIDTH'(1));
                count_d    = count_q + (EXP_WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            residual_q <= '0;
            zero_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            zero_q     <= zero_d;
            count_q    <= count_d;
        end
    end

endmodule
